// File: rtl/noc_route_split.sv
// Routing stage: decodes each packet's destination field and steers it into a local (port 0)
// or forward (port 1) FIFO, each feeding one input of the downstream merge.
module noc_route_split #(
    parameter int unsigned WIDTH    = 49,
    parameter int unsigned ADDR_LSB = 41,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned MY_ADDR  = 0,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out0_valid_o,
    input  logic             out0_ready_i,
    output logic [WIDTH-1:0] out0_data_o,
    output logic             out1_valid_o,
    input  logic             out1_ready_i,
    output logic [WIDTH-1:0] out1_data_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [ADDR_W-1:0] dest;
    logic              sel;
    logic [1:0]        full;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [WIDTH-1:0]  out_data [2];
    logic [CNT_W-1:0]  cnt      [2];

    assign dest       = in_data_i[ADDR_LSB +: ADDR_W];
    assign sel        = (dest == ADDR_W'(MY_ADDR)) ? 1'b0 : 1'b1;
    // A full target blocks the input even when the other queue has room.
    assign in_ready_o = rst_ni && !full[sel];
    assign out_ready  = {out1_ready_i, out0_ready_i};

    for (genvar n = 0; n < 2; n++) begin : g_port
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PtrW:0]    wptr_q, wptr_d;
        logic [PtrW:0]    rptr_q, rptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             empty;
        logic             push;
        logic             pop;

        assign empty   = (wptr_q == rptr_q);
        assign full[n] = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                         (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
        assign push    = in_valid_i && in_ready_o && (sel == 1'(n));
        assign pop     = !empty && out_ready[n];

        assign out_valid[n] = !empty;
        // Mask the head so stale storage never shows after reset or drain.
        assign out_data[n]  = empty ? '0 : mem_q[rptr_q[PtrW-1:0]];
        assign cnt[n]       = cnt_q;

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (push) begin
                wptr_d = wptr_q + (PtrW+1)'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + (PtrW+1)'(1);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
                if (push) begin
                    mem_q[wptr_q[PtrW-1:0]] <= in_data_i;
                end
            end
        end
    end

    assign out0_valid_o = out_valid[0];
    assign out1_valid_o = out_valid[1];
    assign out0_data_o  = out_data[0];
    assign out1_data_o  = out_data[1];
    assign cnt0_o       = cnt[0];
    assign cnt1_o       = cnt[1];

endmodule

// File: tb/tb_noc_route_split.sv
// Directed bench for noc_route_split: routing table, backpressure, head-of-line blocking,
// mid-run reset and a scoreboarded stream.
module tb_noc_route_split;

    localparam int W = 49;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out0_valid, out0_ready;
    logic [W-1:0] out0_data;
    logic         out1_valid, out1_ready;
    logic [W-1:0] out1_data;
    logic [15:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    noc_route_split #(
        .WIDTH(49), .ADDR_LSB(41), .ADDR_W(4), .MY_ADDR(0), .DEPTH(2), .CNT_W(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out0_valid_o (out0_valid),
        .out0_ready_i (out0_ready),
        .out0_data_o  (out0_data),
        .out1_valid_o (out1_valid),
        .out1_ready_i (out1_ready),
        .out1_data_o  (out1_data),
        .cnt0_o       (cnt0),
        .cnt1_o       (cnt1)
    );

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] pl;
        logic        port;
    } vec_t;

    vec_t         vecs [5];
    int           checks = 0;
    int           errors = 0;
    int           stalls = 0;
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] mk(input logic [3:0] dest, input logic [15:0] pl);
        logic [W-1:0] p;
        p          = '0;
        p[44:41]   = dest;
        p[48:45]   = ~dest;
        p[40:25]   = ~pl;
        p[15:0]    = pl;
        return p;
    endfunction

    // Compare visible heads against the scoreboard; both readies are high so each head pops.
    task automatic sb_check();
        if (out0_valid) begin
            if (q0.size() == 0) chk("stream0_extra", 1, 0);
            else chk("stream0_data", out0_data, q0.pop_front());
        end
        if (out1_valid) begin
            if (q1.size() == 0) chk("stream1_extra", 1, 0);
            else chk("stream1_data", out1_data, q1.pop_front());
        end
    endtask

    initial begin
        logic [W-1:0] pkt, pa, pb, pc, pd;
        logic [1:0]   exp_v;

        vecs[0] = '{4'h0, 16'h1234, 1'b0};
        vecs[1] = '{4'h5, 16'hABCD, 1'b1};
        vecs[2] = '{4'hF, 16'h5555, 1'b1};
        vecs[3] = '{4'h0, 16'h0001, 1'b0};
        vecs[4] = '{4'h8, 16'h7777, 1'b1};

        // Reset with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; in_data = mk(4'h0, 16'h0042);
        out0_ready = 1'b0; out1_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            mid();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_valids", {out1_valid, out0_valid}, 0);
            chk("rst_cnt0", cnt0, 0);
            chk("rst_cnt1", cnt1, 0);
            chk("rst_data0", out0_data, 0);
            chk("rst_data1", out1_data, 0);
        end
        tick();
        rst_n = 1'b1; in_valid = 1'b0;

        // Routing table
        for (int i = 0; i < 5; i++) begin
            pkt = mk(vecs[i].dest, vecs[i].pl);
            in_valid = 1'b1; in_data = pkt; out0_ready = 1'b1; out1_ready = 1'b1;
            mid();
            chk("route_in_ready", in_ready, 1);
            chk("route_no_bypass", {out1_valid, out0_valid}, 0);
            tick();
            in_valid = 1'b0;
            mid();
            exp_v = vecs[i].port ? 2'b10 : 2'b01;
            chk("route_valids", {out1_valid, out0_valid}, exp_v);
            chk("route_data", vecs[i].port ? out1_data : out0_data, pkt);
            tick();
        end
        mid();
        chk("route_cnt0", cnt0, 2);
        chk("route_cnt1", cnt1, 3);
        tick();

        // Full / backpressure on port 1
        pa = mk(4'h3, 16'h0101); pb = mk(4'h3, 16'h0202); pc = mk(4'h3, 16'h0303);
        out0_ready = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_data = pa;
        mid(); chk("full_acc1", in_ready, 1); tick();
        in_data = pb;
        mid(); chk("full_acc2", in_ready, 1); tick();
        in_data = pc;
        mid(); chk("full_block", in_ready, 0); chk("full_head1", out1_data, pa); tick();
        out1_ready = 1'b1;
        mid(); chk("full_pop_no_push", in_ready, 0); tick();
        mid(); chk("full_acc3", in_ready, 1); chk("full_head2", out1_data, pb); tick();
        in_valid = 1'b0;
        mid(); chk("full_v3", out1_valid, 1); chk("full_head3", out1_data, pc); tick();
        mid(); chk("full_drained", out1_valid, 0); chk("full_cnt1", cnt1, 6); tick();

        // Head-of-line blocking
        pa = mk(4'h3, 16'h0A0A); pb = mk(4'h3, 16'h0B0B);
        pc = mk(4'h3, 16'h0C0C); pd = mk(4'h0, 16'h0D0D);
        out0_ready = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_data = pa;
        mid(); chk("hol_acc_a", in_ready, 1); tick();
        in_data = pb;
        mid(); chk("hol_acc_b", in_ready, 1); tick();
        in_data = pc;
        for (int i = 0; i < 3; i++) begin
            mid(); chk("hol_block", in_ready, 0); chk("hol_out0_idle", out0_valid, 0); tick();
        end
        out1_ready = 1'b1;
        mid(); chk("hol_still_full", in_ready, 0); tick();
        out1_ready = 1'b0;
        mid(); chk("hol_acc_c", in_ready, 1); tick();
        in_data = pd;
        mid(); chk("hol_acc_d", in_ready, 1); chk("hol_out0_empty", out0_valid, 0); tick();
        in_valid = 1'b0;
        mid(); chk("hol_out0_v", out0_valid, 1); chk("hol_out0_d", out0_data, pd); tick();
        out1_ready = 1'b1;
        mid(); chk("hol_out1_b", out1_data, pb); tick();
        mid(); chk("hol_out1_c", out1_data, pc); tick();
        mid();
        chk("hol_out1_empty", out1_valid, 0);
        chk("hol_cnt0", cnt0, 3);
        chk("hol_cnt1", cnt1, 9);
        tick();

        // Mid-run reset with both FIFOs full
        out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = mk((i < 2) ? 4'h0 : 4'h9, 16'(16'hE000 + i));
            mid(); chk("mrst_fill", in_ready, 1); tick();
        end
        in_valid = 1'b0;
        mid(); chk("mrst_both_valid", {out1_valid, out0_valid}, 2'b11); tick();
        rst_n = 1'b0; in_valid = 1'b1; in_data = mk(4'h0, 16'hBEEF);
        mid(); chk("mrst_in_ready", in_ready, 0); tick();
        rst_n = 1'b1; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("mrst_valids", {out1_valid, out0_valid}, 0);
            chk("mrst_cnt0", cnt0, 0);
            chk("mrst_cnt1", cnt1, 0);
            chk("mrst_data0", out0_data, 0);
            tick();
        end

        // Streaming, alternating destinations
        for (int i = 0; i < 100; i++) begin
            pkt = mk((i % 2 != 0) ? 4'h7 : 4'h0, 16'(i));
            in_valid = 1'b1; in_data = pkt;
            mid();
            sb_check();
            if (!in_ready) stalls++;
            else if (i % 2 != 0) q1.push_back(pkt);
            else q0.push_back(pkt);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid(); sb_check(); tick();
        end
        mid();
        chk("stream_stalls", stalls, 0);
        chk("stream_q0_left", q0.size(), 0);
        chk("stream_q1_left", q1.size(), 0);
        chk("stream_cnt0", cnt0, 50);
        chk("stream_cnt1", cnt1, 50);
        chk("stream_idle", {out1_valid, out0_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
